apvm_delay_checker: RTL and testbench

//  Cycle-based monitor placed downstream of the apvm_delay element. Watches the

---
 rtl/apvm_delay_checker.sv | 123 ++++++++++++
 tb/tb_apvm_delay_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apvm_delay_checker.sv
// Latency monitor for the apvm_delay element: timestamps enabled input
// transitions, matches each to the next output transition and reports latency.
module apvm_delay_checker #(
  parameter int TS_W  = 32,
  parameter int DEPTH = 8,
  parameter int TOL   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              delay,
  input  logic                     in,
  input  logic                     en,
  input  logic                     out,
  output logic                     meas_valid,
  output logic [TS_W-1:0]          meas,
  output logic                     mismatch,
  output logic [15:0]              err_cnt,
  output logic                     spurious,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [TS_W:0] TOL_W    = (TS_W+1)'(TOL);

  logic              in_q;
  logic              out_q;
  logic [TS_W-1:0]   tcnt;
  logic [TS_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              in_e;
  logic              out_e;
  logic              push;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              do_pop;
  logic              do_push;
  logic              drop;
  logic              spur;
  logic              report;
  logic [TS_W-1:0]   dly;
  logic [TS_W-1:0]   meas_nxt;
  logic [TS_W:0]     diff;
  logic [TS_W:0]     abs_diff;
  logic              mm_nxt;

  // An input and output edge in the same cycle on an empty FIFO is a
  // zero-latency match, so it never touches the FIFO.
  always_comb begin
    in_e     = in ^ in_q;
    out_e    = out ^ out_q;
    push     = in_e & en;
    empty    = (pending == '0);
    full     = (pending == FULL_LVL);
    bypass   = push & out_e & empty;
    do_pop   = out_e & ~empty;
    do_push  = push & ~bypass & (~full | do_pop);
    drop     = push & full & ~do_pop;
    spur     = out_e & empty & ~push;
    report   = bypass | do_pop;
    dly      = delay[TS_W-1:0];
    meas_nxt = bypass ? '0 : (tcnt - mem[rd_ptr]);
    diff     = {1'b0, meas_nxt} - {1'b0, dly};
    abs_diff = diff[TS_W] ? (~diff + 1'b1) : diff;
    mm_nxt   = (abs_diff > TOL_W);
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= tcnt;
    end
  end

  always_ff @(posedge clk) begin
    in_q  <= in;
    out_q <= out;
    if (reset) begin
      tcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      meas_valid <= 1'b0;
      meas       <= '0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
      spurious   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      tcnt       <= tcnt + 1'b1;
      meas_valid <= report;
      if (report) begin
        meas     <= meas_nxt;
        mismatch <= mm_nxt;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
      if (spur) begin
        spurious <= 1'b1;
      end
      // A cycle is either a spurious edge or a (possibly mismatched) pop, never both.
      if ((spur || (report && mm_nxt)) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apvm_delay_checker.sv
// Scoreboard bench: three checker instances (default, TOL=2, TS_W=8) share one
// stimulus stream; expected measurements are queued and popped by monitors.
module tb_apvm_delay_checker;

  typedef struct {
    logic [31:0] meas;
    logic        mm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] delay;
  logic        din;
  logic        en;
  logic        dout;

  logic        mv0, mv1, mv2;
  logic [31:0] meas0, meas1;
  logic [7:0]  meas2;
  logic        mm0, mm1, mm2;
  logic [15:0] err0, err1, err2;
  logic        sp0, sp1, sp2;
  logic        ovf0, ovf1, ovf2;
  logic [3:0]  pend0, pend1, pend2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int passed = 0;
  int tk = 0;

  always #5 clk = ~clk;

  apvm_delay_checker #(.TS_W(32), .DEPTH(8), .TOL(0)) dut0 (
    .clk(clk), .reset(reset), .delay(delay), .in(din), .en(en), .out(dout),
    .meas_valid(mv0), .meas(meas0), .mismatch(mm0), .err_cnt(err0),
    .spurious(sp0), .ovf(ovf0), .pending(pend0)
  );

  apvm_delay_checker #(.TS_W(32), .DEPTH(8), .TOL(2)) dut1 (
    .clk(clk), .reset(reset), .delay(delay), .in(din), .en(en), .out(dout),
    .meas_valid(mv1), .meas(meas1), .mismatch(mm1), .err_cnt(err1),
    .spurious(sp1), .ovf(ovf1), .pending(pend1)
  );

  apvm_delay_checker #(.TS_W(8), .DEPTH(8), .TOL(0)) dut2 (
    .clk(clk), .reset(reset), .delay(delay), .in(din), .en(en), .out(dout),
    .meas_valid(mv2), .meas(meas2), .mismatch(mm2), .err_cnt(err2),
    .spurious(sp2), .ovf(ovf2), .pending(pend2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One cycle: optional toggles of in/out applied after the falling edge.
  task automatic applyStimulus(input bit tin, input bit tout);
    if (tin) din = ~din;
    if (tout) dout = ~dout;
    @(negedge clk);
    tk++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic expectMeas(input int m);
    int d;
    exp_t e;
    d = m - int'(delay);
    if (d < 0) d = -d;
    e.meas = m;
    e.mm = (d > 0);
    q0.push_back(e);
    q2.push_back(e);
    e.mm = (d > 2);
    q1.push_back(e);
  endtask

  task automatic checkFlags(input string tag, input int pend, input bit sp, input bit ov,
                            input int e0, input int e1);
    checkOutput({tag, "_pending0"}, pend0, pend);
    checkOutput({tag, "_pending1"}, pend1, pend);
    checkOutput({tag, "_pending2"}, pend2, pend);
    checkOutput({tag, "_spurious0"}, sp0, sp);
    checkOutput({tag, "_spurious1"}, sp1, sp);
    checkOutput({tag, "_spurious2"}, sp2, sp);
    checkOutput({tag, "_ovf0"}, ovf0, ov);
    checkOutput({tag, "_ovf1"}, ovf1, ov);
    checkOutput({tag, "_ovf2"}, ovf2, ov);
    checkOutput({tag, "_err0"}, err0, e0);
    checkOutput({tag, "_err1"}, err1, e1);
    checkOutput({tag, "_err2"}, err2, e0);
  endtask

  // Monitors: every meas_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mv0 === 1'b1) begin : mon0
      exp_t e;
      if (q0.size() == 0) checkOutput("dut0_unexpected_meas_valid", 1, 0);
      else begin
        e = q0.pop_front();
        checkOutput("dut0_meas", meas0, e.meas);
        checkOutput("dut0_mismatch", mm0, e.mm);
      end
    end
  end

  always @(negedge clk) begin
    if (mv1 === 1'b1) begin : mon1
      exp_t e;
      if (q1.size() == 0) checkOutput("dut1_unexpected_meas_valid", 1, 0);
      else begin
        e = q1.pop_front();
        checkOutput("dut1_meas", meas1, e.meas);
        checkOutput("dut1_mismatch", mm1, e.mm);
      end
    end
  end

  always @(negedge clk) begin
    if (mv2 === 1'b1) begin : mon2
      exp_t e;
      if (q2.size() == 0) checkOutput("dut2_unexpected_meas_valid", 1, 0);
      else begin
        e = q2.pop_front();
        checkOutput("dut2_meas", {24'd0, meas2}, e.meas);
        checkOutput("dut2_mismatch", mm2, e.mm);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pt[$];
    reset = 1'b1;
    delay = 32'd5;
    din = 1'b0;
    dout = 1'b0;
    en = 1'b1;
    @(negedge clk);
    applyReset();
    checkOutput("reset_meas_valid0", mv0, 0);
    checkOutput("reset_meas0", meas0, 0);
    checkOutput("reset_mismatch0", mm0, 0);
    checkFlags("reset", 0, 0, 0, 0, 0);

    // Nominal latency 5, twice
    idle(3);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 1'b0);
      idle(4);
      expectMeas(5);
      applyStimulus(1'b0, 1'b1);
      idle(4);
    end
    checkFlags("nominal", 0, 0, 0, 0, 0);

    // Latency 7 against delay 5: mismatch at TOL=0, exactly on the edge at TOL=2
    applyStimulus(1'b1, 1'b0);
    idle(6);
    expectMeas(7);
    applyStimulus(1'b0, 1'b1);
    idle(2);
    checkFlags("late", 0, 0, 0, 1, 0);

    // Spurious output edges, including after a disabled input edge
    applyReset();
    applyStimulus(1'b0, 1'b1);
    idle(2);
    checkFlags("spur1", 0, 1, 0, 1, 1);
    en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1);
    en = 1'b1;
    idle(2);
    checkFlags("spur2", 0, 1, 0, 2, 2);

    // Fill, push+pop while full, overflow, then drain in order
    applyReset();
    for (int i = 0; i < 8; i++) begin
      pt.push_back(tk);
      applyStimulus(1'b1, 1'b0);
    end
    checkFlags("full", 8, 0, 0, 0, 0);
    expectMeas(tk - pt.pop_front());
    pt.push_back(tk);
    applyStimulus(1'b1, 1'b1);
    checkFlags("fullpp", 8, 0, 0, 1, 1);
    applyStimulus(1'b1, 1'b0);
    checkFlags("ovf", 8, 0, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      expectMeas(tk - pt.pop_front());
      applyStimulus(1'b0, 1'b1);
    end
    idle(1);
    checkFlags("drain", 0, 0, 1, 9, 9);

    // Reset with entries pending and an output edge in flight
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkFlags("pre_rst", 3, 0, 1, 9, 9);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    idle(1);
    checkOutput("midrst_meas_valid0", mv0, 0);
    checkFlags("midrst", 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1);
    idle(1);
    checkFlags("post_rst", 0, 1, 0, 1, 1);

    // Zero delay bypass
    applyReset();
    delay = 32'd0;
    expectMeas(0);
    applyStimulus(1'b1, 1'b1);
    idle(1);
    checkFlags("bypass", 0, 0, 0, 0, 0);

    // Timestamp wrap on the 8-bit instance: in at tcnt 250, out at tcnt 260 (=4)
    applyReset();
    delay = 32'd10;
    idle(250);
    applyStimulus(1'b1, 1'b0);
    idle(9);
    expectMeas(10);
    applyStimulus(1'b0, 1'b1);
    idle(2);
    checkFlags("wrap", 0, 0, 0, 0, 0);

    idle(2);
    checkOutput("q0_drained", q0.size(), 0);
    checkOutput("q1_drained", q1.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
